// File: rtl/spmd_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spmd_run_sequencer
// Brief    : Run-control sequencer (core reset, load, run, finish/fail/timeout)
//            with print_stat decode and RUN cycle counter.
//            Optional heartbeat: define SPMD_RUN_SEQ_HEARTBEAT_EN.
// Revision : 1.0
// ============================================================================
module spmd_run_sequencer #(
  parameter int reset_depth_p    = 3,
  parameter int num_finish_p     = 1,
  parameter int ctr_width_p      = 32,
  parameter int timeout_cycles_p = 0,
  parameter int data_width_p     = 32,
  parameter int hb_log_p         = 10
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    tag_done_i,
  input  logic                    loader_done_i,
  input  logic                    print_stat_v_i,
  input  logic [data_width_p-1:0] print_stat_tag_i,
  output logic                    core_reset_o,
  output logic [2:0]              state_o,
  output logic [ctr_width_p-1:0]  cycle_ctr_o,
  output logic                    stat_v_o,
  output logic [29:0]             stat_tag_o,
  output logic [ctr_width_p-1:0]  stat_cycle_o,
  output logic                    done_o,
  output logic                    fail_o,
  output logic                    timeout_o,
  output logic                    heartbeat_o
);

  typedef enum logic [2:0] {
    ST_UNUSED   = 3'd0,
    ST_WAIT_TAG = 3'd1,
    ST_RELEASE  = 3'd2,
    ST_LOAD     = 3'd3,
    ST_RUN      = 3'd4,
    ST_DONE     = 3'd5,
    ST_FAIL     = 3'd6,
    ST_TIMEOUT  = 3'd7
  } state_t;

  localparam int c_rel_w = (reset_depth_p > 1) ? $clog2(reset_depth_p) : 1;
  localparam int c_fin_w = (num_finish_p > 0) ? $clog2(num_finish_p + 1) : 1;
  localparam logic [c_rel_w-1:0]     c_rel_init   = c_rel_w'(reset_depth_p - 1);
  localparam logic [c_fin_w-1:0]     c_fin_target = c_fin_w'(num_finish_p);
  localparam logic [ctr_width_p-1:0] c_to_last    =
      ctr_width_p'((timeout_cycles_p > 0) ? timeout_cycles_p - 1 : 0);
  localparam bit                     c_to_en      = (timeout_cycles_p != 0);

  // Configurations the datapath cannot represent are rejected at elaboration.
  if (reset_depth_p < 1 || num_finish_p < 1 || data_width_p != 32) begin : g_cfg_bad
    $error("spmd_run_sequencer: unsupported reset_depth_p/num_finish_p/data_width_p");
  end
  if (hb_log_p < 1 || hb_log_p >= ctr_width_p) begin : g_hb_cfg_bad
    $error("spmd_run_sequencer: hb_log_p out of range");
  end

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [c_rel_w-1:0]       r_rel_cnt;
  logic [c_rel_w-1:0]       w_rel_cnt_nxt;
  logic [c_fin_w-1:0]       r_fin_cnt;
  logic [c_fin_w-1:0]       w_fin_cnt_nxt;
  logic [c_fin_w-1:0]       w_fin_inc;
  logic [ctr_width_p-1:0]   r_ctr;
  logic [ctr_width_p-1:0]   w_ctr_nxt;
  logic                     r_stat_v;
  logic                     w_stat_v_nxt;
  logic [29:0]              r_stat_tag;
  logic [29:0]              w_stat_tag_nxt;
  logic [ctr_width_p-1:0]   r_stat_cycle;
  logic [ctr_width_p-1:0]   w_stat_cycle_nxt;
  logic                     r_core_reset;
  logic                     r_done;
  logic                     r_fail;
  logic                     r_timeout;

  logic [1:0]               w_tag_type;
  logic [29:0]              w_tag_payload;
  logic                     w_is_stat;
  logic                     w_is_finish;
  logic                     w_is_fail;
  logic                     w_ctr_sat;
  logic                     w_timeout_hit;

  assign w_tag_type    = print_stat_tag_i[31:30];
  assign w_tag_payload = print_stat_tag_i[29:0];
  assign w_is_stat     = print_stat_v_i && (w_tag_type == 2'b00);
  assign w_is_finish   = print_stat_v_i && (w_tag_type == 2'b01);
  assign w_is_fail     = print_stat_v_i && (w_tag_type == 2'b10);
  assign w_fin_inc     = r_fin_cnt + 1'b1;
  assign w_ctr_sat     = &r_ctr;
  assign w_timeout_hit = c_to_en && (r_ctr == c_to_last);

  always_comb begin
    w_state_nxt      = r_state;
    w_rel_cnt_nxt    = r_rel_cnt;
    w_fin_cnt_nxt    = r_fin_cnt;
    w_ctr_nxt        = r_ctr;
    w_stat_v_nxt     = 1'b0;
    w_stat_tag_nxt   = r_stat_tag;
    w_stat_cycle_nxt = r_stat_cycle;
    case (r_state)
      ST_WAIT_TAG: begin
        if (tag_done_i) begin
          w_state_nxt   = ST_RELEASE;
          w_rel_cnt_nxt = c_rel_init;
        end
      end
      ST_RELEASE: begin
        // A dropped tag_done means programming restarted; hold the core in reset.
        if (!tag_done_i) begin
          w_state_nxt = ST_WAIT_TAG;
        end else if (r_rel_cnt == '0) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_rel_cnt_nxt = r_rel_cnt - 1'b1;
        end
      end
      ST_LOAD: begin
        if (loader_done_i) begin
          w_state_nxt   = ST_RUN;
          w_ctr_nxt     = '0;
          w_fin_cnt_nxt = '0;
        end
      end
      ST_RUN: begin
        w_ctr_nxt = w_ctr_sat ? r_ctr : r_ctr + 1'b1;
        if (w_is_stat) begin
          w_stat_v_nxt     = 1'b1;
          w_stat_tag_nxt   = w_tag_payload;
          w_stat_cycle_nxt = r_ctr;
        end
        if (w_is_finish) begin
          w_fin_cnt_nxt = w_fin_inc;
        end
        // Priority: fail, then finish-complete, then timeout.
        if (w_is_fail) begin
          w_state_nxt = ST_FAIL;
        end else if (w_is_finish && (w_fin_inc == c_fin_target)) begin
          w_state_nxt = ST_DONE;
        end else if (w_timeout_hit) begin
          w_state_nxt = ST_TIMEOUT;
        end
      end
      ST_DONE, ST_FAIL, ST_TIMEOUT: begin
        w_state_nxt = r_state;
      end
      default: begin
        w_state_nxt = ST_WAIT_TAG;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= ST_WAIT_TAG;
      r_rel_cnt    <= '0;
      r_fin_cnt    <= '0;
      r_ctr        <= '0;
      r_stat_v     <= 1'b0;
      r_stat_tag   <= '0;
      r_stat_cycle <= '0;
      r_core_reset <= 1'b1;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rel_cnt    <= w_rel_cnt_nxt;
      r_fin_cnt    <= w_fin_cnt_nxt;
      r_ctr        <= w_ctr_nxt;
      r_stat_v     <= w_stat_v_nxt;
      r_stat_tag   <= w_stat_tag_nxt;
      r_stat_cycle <= w_stat_cycle_nxt;
      r_core_reset <= (w_state_nxt == ST_WAIT_TAG) || (w_state_nxt == ST_RELEASE);
      r_done       <= r_done    | (w_state_nxt == ST_DONE);
      r_fail       <= r_fail    | (w_state_nxt == ST_FAIL);
      r_timeout    <= r_timeout | (w_state_nxt == ST_TIMEOUT);
    end
  end

`ifdef SPMD_RUN_SEQ_HEARTBEAT_EN
  logic r_hb;
  logic w_hb_wrap;

  // Pulse in the cycle where the counter shows a nonzero multiple of 2^hb_log_p.
  assign w_hb_wrap = (r_state == ST_RUN) && (w_ctr_nxt[hb_log_p-1:0] == '0) &&
                     (w_ctr_nxt != '0);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_hb <= 1'b0;
    end else begin
      r_hb <= w_hb_wrap;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (r_hb) begin
      $display("spmd_run_sequencer heartbeat: cycle=%0d fin_cnt=%0d", r_ctr, r_fin_cnt);
    end
  end
`endif

  assign heartbeat_o = r_hb;
`else
  assign heartbeat_o = 1'b0;
`endif

  assign core_reset_o = r_core_reset;
  assign state_o      = r_state;
  assign cycle_ctr_o  = r_ctr;
  assign stat_v_o     = r_stat_v;
  assign stat_tag_o   = r_stat_tag;
  assign stat_cycle_o = r_stat_cycle;
  assign done_o       = r_done;
  assign fail_o       = r_fail;
  assign timeout_o    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_spmd_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spmd_run_sequencer
// Brief    : Self-checking bench: directed run scenarios plus randomized runs
//            against a phase-level reference model.
// Revision : 1.0
// ============================================================================
module tb_spmd_run_sequencer;

  localparam int c_rd = 3;
  localparam int c_nf = 2;
  localparam int c_to = 50;
  localparam int c_cw = 32;

  localparam logic [31:0] c_fin_tag  = 32'h4000_0000;
  localparam logic [31:0] c_fail_tag = 32'h8000_0001;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            tag_done = 1'b0;
  logic            loader_done = 1'b0;
  logic            ps_v = 1'b0;
  logic [31:0]     ps_tag = '0;

  logic            core_reset;
  logic [2:0]      state;
  logic [c_cw-1:0] cycle_ctr;
  logic            stat_v;
  logic [29:0]     stat_tag;
  logic [c_cw-1:0] stat_cycle;
  logic            done;
  logic            fail;
  logic            timeout;
  logic            heartbeat;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  spmd_run_sequencer #(
    .reset_depth_p   (c_rd),
    .num_finish_p    (c_nf),
    .ctr_width_p     (c_cw),
    .timeout_cycles_p(c_to),
    .data_width_p    (32),
    .hb_log_p        (4)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .tag_done_i      (tag_done),
    .loader_done_i   (loader_done),
    .print_stat_v_i  (ps_v),
    .print_stat_tag_i(ps_tag),
    .core_reset_o    (core_reset),
    .state_o         (state),
    .cycle_ctr_o     (cycle_ctr),
    .stat_v_o        (stat_v),
    .stat_tag_o      (stat_tag),
    .stat_cycle_o    (stat_cycle),
    .done_o          (done),
    .fail_o          (fail),
    .timeout_o       (timeout),
    .heartbeat_o     (heartbeat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, req, $time);
    end
  endtask

  // Reference model: phase number, high-sample count since tag_done rose,
  // RUN cycle count, finish tags seen, last stat and sticky flags.
  int          m_state = 1;
  int          m_hi    = 0;
  logic [31:0] m_ctr   = '0;
  logic [31:0] m_old;
  int          m_fin   = 0;
  int          m_nxt;
  bit          m_sv    = 1'b0;
  logic [29:0] m_stag  = '0;
  logic [31:0] m_scyc  = '0;
  bit          m_done  = 1'b0;
  bit          m_fail  = 1'b0;
  bit          m_to    = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state = 1; m_hi = 0; m_ctr = '0; m_fin = 0; m_sv = 1'b0;
      m_stag = '0; m_scyc = '0; m_done = 1'b0; m_fail = 1'b0; m_to = 1'b0;
    end else begin
      m_sv = 1'b0;
      case (m_state)
        1: if (tag_done) begin m_state = 2; m_hi = 0; end
        2: begin
          if (!tag_done) m_state = 1;
          else begin
            m_hi++;
            if (m_hi == c_rd) m_state = 3;
          end
        end
        3: if (loader_done) begin m_state = 4; m_ctr = '0; m_fin = 0; end
        4: begin
          m_old = m_ctr;
          if (m_ctr != 32'hFFFF_FFFF) m_ctr = m_ctr + 1;
          m_nxt = 4;
          // Lower-priority outcomes are written first and overwritten by higher ones.
          if (m_old == 32'(c_to - 1)) m_nxt = 7;
          if (ps_v) begin
            case (ps_tag[31:30])
              2'b00: begin m_sv = 1'b1; m_stag = ps_tag[29:0]; m_scyc = m_old; end
              2'b01: begin m_fin++; if (m_fin == c_nf) m_nxt = 5; end
              2'b10: m_nxt = 6;
              default: ;
            endcase
          end
          m_state = m_nxt;
          if (m_state == 5) m_done = 1'b1;
          if (m_state == 6) m_fail = 1'b1;
          if (m_state == 7) m_to = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("cmp_state", state, m_state);
      chk("cmp_core_reset", core_reset, (m_state <= 2));
      chk("cmp_cycle_ctr", cycle_ctr, m_ctr);
      chk("cmp_stat_v", stat_v, m_sv);
      chk("cmp_stat_tag", stat_tag, m_stag);
      chk("cmp_stat_cycle", stat_cycle, m_scyc);
      chk("cmp_done", done, m_done);
      chk("cmp_fail", fail, m_fail);
      chk("cmp_timeout", timeout, m_to);
      chk("cmp_heartbeat", heartbeat, 1'b0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; tag_done = 1'b0; loader_done = 1'b0; ps_v = 1'b0; ps_tag = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic send_tag(input logic [31:0] t);
    ps_v = 1'b1; ps_tag = t;
    @(posedge clk); #2;
    ps_v = 1'b0;
  endtask

  task automatic wait_state(input int s, input int budget);
    int i = 0;
    while (state != 3'(s) && i < budget) begin @(negedge clk); i++; end
    chk("wait_state", state, s);
  endtask

  task automatic wait_ctr(input logic [31:0] v);
    int i = 0;
    @(negedge clk);
    while (cycle_ctr != v && i < 200) begin @(negedge clk); i++; end
    chk("wait_ctr", cycle_ctr, v);
  endtask

  task automatic to_run();
    do_reset();
    @(negedge clk) tag_done = 1'b1;
    wait_state(3, 20);
    loader_done = 1'b1;
    wait_state(4, 10);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rnd;
    int          ty;
    #2 reset_n = 1'b0;
    #1 cmp_en = 1'b1;
    chk("rst_state", state, 1);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_ctr", cycle_ctr, 0);
    chk("rst_done", done, 0);

    // Release timing and a normal two-finish run.
    do_reset();
    @(negedge clk) tag_done = 1'b1;
    @(posedge clk); #2;
    chk("rel_e0_state", state, 2);
    chk("rel_e0_core_reset", core_reset, 1);
    repeat (2) begin @(posedge clk); #2; end
    chk("rel_e2_core_reset", core_reset, 1);
    @(posedge clk); #2;
    chk("rel_e3_core_reset", core_reset, 0);
    chk("rel_e3_state", state, 3);
    @(negedge clk) loader_done = 1'b1;
    @(posedge clk); #2;
    chk("run_entry_state", state, 4);
    chk("run_entry_ctr", cycle_ctr, 0);
    wait_ctr(10);
    send_tag(32'h0000_0007);
    chk("stat_v", stat_v, 1);
    chk("stat_tag", stat_tag, 7);
    chk("stat_cycle", stat_cycle, 10);
    @(negedge clk) send_tag(c_fin_tag);
    chk("fin1_state", state, 4);
    chk("fin1_done", done, 0);
    @(negedge clk) send_tag(c_fin_tag);
    chk("fin2_state", state, 5);
    chk("fin2_done", done, 1);
    chk("fin2_ctr", cycle_ctr, 13);
    chk("model_ctr_pin", m_ctr, 13);
    repeat (5) @(negedge clk);
    chk("done_frozen_ctr", cycle_ctr, 13);
    chk("done_hold_state", state, 5);

    // Fail tag arriving together with the timeout edge.
    to_run();
    wait_ctr(49);
    send_tag(c_fail_tag);
    chk("pri_fail_state", state, 6);
    chk("pri_fail_flag", fail, 1);
    chk("pri_fail_timeout", timeout, 0);

    // Final finish tag together with the timeout edge.
    to_run();
    wait_ctr(20);
    send_tag(c_fin_tag);
    wait_ctr(49);
    send_tag(c_fin_tag);
    chk("pri_fin_state", state, 5);
    chk("pri_fin_timeout", timeout, 0);

    // Plain timeout.
    to_run();
    wait_state(7, 100);
    chk("to_ctr", cycle_ctr, 50);
    chk("to_flag", timeout, 1);
    chk("model_to_pin", m_to, 1);

    // Abort mid-run.
    to_run();
    wait_ctr(15);
    reset_n = 1'b0;
    #1;
    chk("abort_state", state, 1);
    chk("abort_core_reset", core_reset, 1);
    chk("abort_ctr", cycle_ctr, 0);
    chk("abort_flags", {done, fail, timeout, stat_v}, 0);
    @(negedge clk) reset_n = 1'b1;

    // tag_done glitch during release.
    do_reset();
    @(negedge clk) tag_done = 1'b1;
    repeat (2) @(negedge clk);
    tag_done = 1'b0;
    @(posedge clk); #2;
    chk("glitch_state", state, 1);
    chk("glitch_core_reset", core_reset, 1);
    @(negedge clk) tag_done = 1'b1;
    wait_state(3, 20);

    // Randomized runs, checked cycle by cycle against the model.
    for (int r = 0; r < 30; r++) begin
      do_reset();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      tag_done = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        repeat (2) @(negedge clk);
        tag_done = 1'b0;
        @(negedge clk) tag_done = 1'b1;
      end
      for (int c = 0; c < 60 && m_state != 3; c++) begin
        @(negedge clk);
        ps_v = ($urandom_range(0, 3) == 0);
        ps_tag = $urandom;
      end
      ps_v = 1'b0;
      wait_state(3, 20);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      loader_done = 1'b1;
      for (int c = 0; c < 80 && !(m_state inside {5, 6, 7}); c++) begin
        @(negedge clk);
        rnd = $urandom;
        ty  = $urandom_range(0, 19);
        ps_v = ($urandom_range(0, 2) == 0);
        ps_tag = {(ty < 10) ? 2'b00 : (ty < 15) ? 2'b01 : (ty == 15) ? 2'b10 : 2'b11,
                  rnd[29:0]};
      end
      @(negedge clk) ps_v = 1'b0;
      repeat (3) @(negedge clk);
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
